// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC register and IF/ID pipeline register
//
// Purpose:
//   Holds the program counter and presents it combinationally to the
//   instruction memory. Registers the returned word with its PC, a
//   branch-delay-slot flag, a fetch exception code and a valid bit into the
//   IF/ID pipeline register.
//
// Optional feature:
//   FETCH_ADDR_CHECK_EN - when defined, fetches from a misaligned PC or a PC
//   outside the instruction memory are replaced by a nop tagged with
//   exccode 4 (AdEL). When undefined, every word is captured as fetched and
//   if_id_exccode stays 0.
//
// Parameters:
//   PC_RESET     - PC value after reset
//   HANDLER_ADDR - exception entry address
//   IM_BASE      - lowest legal fetch address
//   IM_WORDS     - instruction memory depth in words
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   stall         in   hold PC and IF/ID
//   npc_sel       in   take branch/jump target npc
//   npc[31:0]     in   branch/jump target
//   req_exc       in   exception committed downstream, enter handler
//   eret          in   return from exception to epc
//   epc[31:0]     in   return address for eret
//   im_addr[31:0] out  current PC to instruction memory
//   im_data[31:0] in   instruction word, combinational from im_addr
//   if_id_instr   out  registered instruction
//   if_id_pc      out  registered PC of that instruction
//   if_id_bd      out  instruction sits in a branch delay slot
//   if_id_exccode out  0 = none, 4 = AdEL on fetch
//   if_id_valid   out  IF/ID holds a real fetch (0 = bubble)

module if_stage #(
  parameter logic [31:0] PC_RESET     = 32'h0000_3000,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] IM_BASE      = 32'h0000_3000,
  parameter int          IM_WORDS     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        npc_sel,
  input  logic [31:0] npc,
  input  logic        req_exc,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_bd,
  output logic [4:0]  if_id_exccode,
  output logic        if_id_valid
);

  // Address of the last word in instruction memory.
  localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        ifid_load;
  logic        ifid_flush;
  logic        bd_next;
  logic        addr_bad;
  logic        fetch_fault;

  assign im_addr = pc;

  // The range test is always elaborated; CHECK_EN removes it from the
  // default build so the captured word is never altered there.
  assign addr_bad    = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
  assign fetch_fault = CHECK_EN & addr_bad;

  // Next-PC and IF/ID control, highest priority first. Exception entry and
  // eret both discard the word currently being fetched, and they override
  // the hazard stall because the downstream pipeline is being flushed too.
  always_comb begin
    pc_next    = pc + 32'd4;
    ifid_load  = 1'b1;
    ifid_flush = 1'b0;
    bd_next    = 1'b0;
    if (req_exc) begin
      pc_next    = HANDLER_ADDR;
      ifid_load  = 1'b0;
      ifid_flush = 1'b1;
    end else if (eret) begin
      pc_next    = epc;
      ifid_load  = 1'b0;
      ifid_flush = 1'b1;
    end else if (stall) begin
      // ID keeps npc_sel/npc asserted, so a redirect is taken once stall drops.
      pc_next   = pc;
      ifid_load = 1'b0;
    end else if (npc_sel) begin
      // The word fetched this cycle is the delay slot of the branch in ID.
      pc_next = npc;
      bd_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= PC_RESET;
      if_id_instr   <= 32'd0;
      if_id_pc      <= 32'd0;
      if_id_bd      <= 1'b0;
      if_id_exccode <= EXC_NONE;
      if_id_valid   <= 1'b0;
    end else begin
      pc <= pc_next;
      if (ifid_flush) begin
        if_id_instr   <= 32'd0;
        if_id_pc      <= 32'd0;
        if_id_bd      <= 1'b0;
        if_id_exccode <= EXC_NONE;
        if_id_valid   <= 1'b0;
      end else if (ifid_load) begin
        // A faulting fetch travels on as a nop carrying the bad PC; the PC
        // keeps advancing until the exception comes back as req_exc.
        if_id_instr   <= fetch_fault ? 32'd0 : im_data;
        if_id_pc      <= pc;
        if_id_bd      <= bd_next;
        if_id_exccode <= fetch_fault ? EXC_ADEL : EXC_NONE;
        if_id_valid   <= 1'b1;
      end
    end
  end

endmodule
